// File: rtl/reorder_buffer.sv
// ============================================================================
// Module   : reorder_buffer
// Purpose  : In-order retirement buffer returning old physical registers to
//            the free list. Optional macro ROB_PERF_CNT_EN adds commit_count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 7,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_rd_valid,
  input  logic [PREG_W-1:0] alloc_pd_new,
  input  logic [PREG_W-1:0] alloc_pd_old,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic              mispredict,
  input  logic [TAG_W-1:0]  mispredict_tag,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [PREG_W-1:0] commit_pd_new,
  output logic              free_write_en,
  output logic [PREG_W-1:0] free_data,
  output logic              full,
`ifdef ROB_PERF_CNT_EN
  output logic              empty,
  output logic [31:0]       commit_count
`else
  output logic              empty
`endif
);

  localparam logic [TAG_W:0] C_DEPTH = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] C_ONE   = (TAG_W+1)'(1);

  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic [DEPTH-1:0]  done_q;
  logic [DEPTH-1:0]  rd_valid_q;
  logic [PREG_W-1:0] pd_new_q [DEPTH];
  logic [PREG_W-1:0] pd_old_q [DEPTH];

  logic              w_alloc_fire;
  logic              w_cdb_fire;
  logic              w_commit_fire;
  logic [TAG_W-1:0]  w_cdb_off;
  logic [TAG_W-1:0]  w_mp_off;

  assign empty       = (count_q == '0);
  assign full        = (count_q == C_DEPTH);
  assign alloc_ready = !full;
  assign alloc_tag   = tail_q;

  assign w_alloc_fire = alloc_valid && !full && !mispredict;

  // A CDB tag is live only if its distance from head lies inside the window.
  assign w_cdb_off  = cdb_tag - head_q;
  assign w_cdb_fire = cdb_valid && !mispredict && ({1'b0, w_cdb_off} < count_q);

  assign commit_valid  = !reset && !empty && done_q[head_q] && !mispredict;
  assign w_commit_fire = commit_valid;
  assign commit_tag    = head_q;
  assign commit_pd_new = empty ? '0 : pd_new_q[head_q];
  assign free_data     = empty ? '0 : pd_old_q[head_q];
  assign free_write_en = commit_valid && rd_valid_q[head_q] && (pd_old_q[head_q] != '0);

  assign w_mp_off = mispredict_tag - head_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mispredict) begin
      tail_d  = mispredict_tag + TAG_W'(1);
      count_d = {1'b0, w_mp_off} + C_ONE;
    end else begin
      if (w_commit_fire) begin
        head_d = head_q + TAG_W'(1);
      end
      if (w_alloc_fire) begin
        tail_d = tail_q + TAG_W'(1);
      end
      count_d = count_q + (TAG_W+1)'(w_alloc_fire) - (TAG_W+1)'(w_commit_fire);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // The allocated slot is never live, so it cannot collide with a CDB write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q     <= '0;
      rd_valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pd_new_q[i] <= '0;
        pd_old_q[i] <= '0;
      end
    end else begin
      if (w_alloc_fire) begin
        done_q[tail_q]     <= 1'b0;
        rd_valid_q[tail_q] <= alloc_rd_valid;
        pd_new_q[tail_q]   <= alloc_pd_new;
        pd_old_q[tail_q]   <= alloc_pd_old;
      end
      if (w_cdb_fire) begin
        done_q[cdb_tag] <= 1'b1;
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] commit_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_count_q <= '0;
    end else if (w_commit_fire) begin
      commit_count_q <= commit_count_q + 32'd1;
    end
  end

  assign commit_count = commit_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ============================================================================
// Module   : tb_reorder_buffer
// Purpose  : Randomized and directed checks of reorder_buffer against a
//            queue-based model of the live instruction window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reorder_buffer;

  localparam int DEPTH  = 16;
  localparam int PREG_W = 7;
  localparam int TAG_W  = 4;

  logic              clk;
  logic              reset;
  logic              alloc_valid;
  logic              alloc_ready;
  logic              alloc_rd_valid;
  logic [PREG_W-1:0] alloc_pd_new;
  logic [PREG_W-1:0] alloc_pd_old;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic              mispredict;
  logic [TAG_W-1:0]  mispredict_tag;
  logic              commit_valid;
  logic [TAG_W-1:0]  commit_tag;
  logic [PREG_W-1:0] commit_pd_new;
  logic              free_write_en;
  logic [PREG_W-1:0] free_data;
  logic              full;
  logic              empty;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]       commit_count;
`endif

  reorder_buffer #(.DEPTH(DEPTH), .PREG_W(PREG_W), .TAG_W(TAG_W)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_rd_valid (alloc_rd_valid),
    .alloc_pd_new   (alloc_pd_new),
    .alloc_pd_old   (alloc_pd_old),
    .alloc_tag      (alloc_tag),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .commit_valid   (commit_valid),
    .commit_tag     (commit_tag),
    .commit_pd_new  (commit_pd_new),
    .free_write_en  (free_write_en),
    .free_data      (free_data),
    .full           (full),
`ifdef ROB_PERF_CNT_EN
    .empty          (empty),
    .commit_count   (commit_count)
`else
    .empty          (empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int tag;
    bit rdv;
    int pn;
    int po;
    bit done;
  } ent_t;

  ent_t q[$];
  int   head_m;
  int   cc_m;
  int   n_vec;
  int   n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    head_m = 0;
    cc_m   = 0;
  endtask

  task automatic idle_inputs();
    alloc_valid    = 1'b0;
    alloc_rd_valid = 1'b0;
    alloc_pd_new   = '0;
    alloc_pd_old   = '0;
    cdb_valid      = 1'b0;
    cdb_tag        = '0;
    mispredict     = 1'b0;
    mispredict_tag = '0;
  endtask

  // Asserted mid-cycle, away from any edge, so the async clear is observable at once.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("rst_commit_valid", commit_valid, 1'b0);
    chk("rst_free_we", free_write_en, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_alloc_ready", alloc_ready, 1'b1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_free_data", free_data, 0);
    chk("rst_commit_tag", commit_tag, 0);
    chk("rst_commit_pd_new", commit_pd_new, 0);
`ifdef ROB_PERF_CNT_EN
    chk("rst_commit_count", commit_count, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic cycle(input bit av, input bit rdv, input int pn, input int po,
                       input bit cv, input int ct, input bit mp, input int mt);
    int   n;
    bit   e_cv;
    bit   a_fire;
    int   atag;
    int   idx;
    ent_t e;
    alloc_valid    = av;
    alloc_rd_valid = rdv;
    alloc_pd_new   = PREG_W'(pn);
    alloc_pd_old   = PREG_W'(po);
    cdb_valid      = cv;
    cdb_tag        = TAG_W'(ct);
    mispredict     = mp;
    mispredict_tag = TAG_W'(mt);
    #4;
    n      = q.size();
    e_cv   = (n > 0) && q[0].done && !mp;
    a_fire = av && (n < DEPTH) && !mp;
    atag   = (head_m + n) % DEPTH;
    chk("empty", empty, n == 0);
    chk("full", full, n == DEPTH);
    chk("alloc_ready", alloc_ready, n != DEPTH);
    chk("alloc_tag", alloc_tag, atag);
    chk("commit_valid", commit_valid, e_cv);
    chk("free_we", free_write_en, e_cv && q[0].rdv && (q[0].po != 0));
    chk("free_data", free_data, (n > 0) ? q[0].po : 0);
    if (e_cv) begin
      chk("commit_tag", commit_tag, q[0].tag);
      chk("commit_pd_new", commit_pd_new, q[0].pn);
    end
`ifdef ROB_PERF_CNT_EN
    chk("commit_count", commit_count, cc_m);
`endif
    @(posedge clk);
    if (mp) begin
      idx = -1;
      for (int i = 0; i < n; i++) if (q[i].tag == mt) idx = i;
      if (idx >= 0) begin
        while (q.size() > idx + 1) void'(q.pop_back());
      end
    end else begin
      if (cv) begin
        for (int i = 0; i < n; i++) if (q[i].tag == ct) q[i].done = 1'b1;
      end
      if (e_cv) begin
        void'(q.pop_front());
        head_m = (head_m + 1) % DEPTH;
        cc_m++;
      end
      if (a_fire) begin
        e.tag  = atag;
        e.rdv  = rdv;
        e.pn   = pn % (1 << PREG_W);
        e.po   = po % (1 << PREG_W);
        e.done = 1'b0;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int pa, pc, ct, mt;
    bit mp, cv;
    n_vec = 0;
    n_err = 0;
    model_clear();
    idle_inputs();
    reset = 1'b1;
    #1;
    do_reset();

    // First allocation gets tag 0, the next sees tag 1.
    cycle(1, 1, 10, 20, 0, 0, 0, 0);
    idle(1);

    // Out-of-order completion, in-order retirement.
    do_reset();
    cycle(1, 1, 50, 40, 0, 0, 0, 0);
    cycle(1, 1, 51, 41, 0, 0, 0, 0);
    cycle(1, 1, 52, 42, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 2, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 0, 0);
    idle(3);

    // Fill to DEPTH, refused extra alloc, then wrap reuse of tag 0.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, 1, 60 + i, 80 + i, 0, 0, 0, 0);
    cycle(1, 1, 5, 5, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    cycle(1, 1, 7, 7, 0, 0, 0, 0);
    cycle(1, 1, 9, 9, 0, 0, 0, 0);
    idle(2);

    // No free-list write for rd_valid=0 or pd_old=0.
    do_reset();
    cycle(1, 0, 11, 33, 0, 0, 0, 0);
    cycle(1, 1, 12, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 0, 0);
    idle(2);

    // Mispredict at tag 2 leaves three entries; stale tag 4 is ignored.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 1, 20 + i, 30 + i, 0, 0, 0, 0);
    cycle(1, 1, 99, 99, 1, 3, 1, 2);
    cycle(0, 0, 0, 0, 1, 4, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 2, 0, 0);
    idle(3);

    // Asynchronous reset with a committable head entry.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1, 40 + i, 50 + i, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    alloc_valid = 1'b0;
    cdb_valid   = 1'b0;
    #1;
    chk("pre_rst_commit_valid", commit_valid, q[0].done);
    chk("pre_rst_free_we", free_write_en, q[0].done && q[0].rdv && (q[0].po != 0));
    do_reset();
    idle(1);

    // Randomized traffic with phases biased toward filling or draining.
    for (int i = 0; i < 4000; i++) begin
      case ((i / 200) % 3)
        0:       begin pa = 85; pc = 20; end
        1:       begin pa = 50; pc = 60; end
        default: begin pa = 25; pc = 85; end
      endcase
      cv = ($urandom_range(0, 99) < pc);
      if (q.size() > 0 && $urandom_range(0, 9) < 8)
        ct = q[$urandom_range(0, q.size() - 1)].tag;
      else
        ct = $urandom_range(0, DEPTH - 1);
      mp = (q.size() > 0) && ($urandom_range(0, 99) < 3);
      mt = (q.size() > 0) ? q[$urandom_range(0, q.size() - 1)].tag : 0;
      cycle($urandom_range(0, 99) < pa, $urandom_range(0, 3) != 0,
            $urandom_range(0, 127),
            ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 127),
            cv, ct, mp, mt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
